// File: rtl/win3x3_gen_if.sv
// Stream-in / window-out handshake bundle for win3x3_gen.
// master drives pixels and window acceptance; slave is the window generator.
interface win3x3_gen_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [9*DW-1:0] win_data;
  logic            win_valid;
  logic            win_ready;

  modport master (
    output in_data, in_valid, win_ready,
    input  in_ready, win_data, win_valid
  );

  modport slave (
    input  in_data, in_valid, win_ready,
    output in_ready, win_data, win_valid
  );
endinterface

// File: rtl/win3x3_gen.sv
// 3x3 sliding-window generator over a padded raster stream using two line delays.
// Optional WIN3X3_FLUSH_EN: in the picture-input-done phase, shift zeros to drain the last windows.
module win3x3_gen #(
  parameter int unsigned DW     = 8,
  parameter int unsigned LINE_W = 1026
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   state,
  win3x3_gen_if.slave  bus
);
  localparam int unsigned PtrW    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int unsigned FillMax = 2 * LINE_W + 2;
  localparam int unsigned FillW   = $clog2(FillMax + 1);

  logic                  stall;
  logic                  feed;
  logic                  advance;
  logic [DW-1:0]         din;
  logic [DW-1:0]         line1_out;
  logic [DW-1:0]         line2_out;
  logic [DW-1:0]         line1_mem [LINE_W];
  logic [DW-1:0]         line2_mem [LINE_W];
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [FillW-1:0]      fill_q, fill_d;
  logic [8:0][DW-1:0]    win_q, win_d;
  logic                  win_valid_q, win_valid_d;
  logic                  unused_state;

  assign stall        = win_valid_q && !bus.win_ready;
  assign feed         = state[0] || state[1];
  assign bus.in_ready = !stall && feed;
  assign unused_state = ^state[3:2];

`ifdef WIN3X3_FLUSH_EN
  assign advance = !stall && ((feed && bus.in_valid) || state[2]);
  assign din     = feed ? bus.in_data : '0;
`else
  assign advance = feed && bus.in_valid && !stall;
  assign din     = bus.in_data;
`endif

  // Read-before-write: the slot at ptr holds the sample from exactly LINE_W advances ago.
  assign line1_out = line1_mem[ptr_q];
  assign line2_out = line2_mem[ptr_q];

  // Storage is never reset; the fill count keeps stale entries off a valid window.
  always_ff @(posedge clk) begin
    if (advance) begin
      line1_mem[ptr_q] <= din;
      line2_mem[ptr_q] <= line1_out;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    if (advance) begin
      ptr_d       = (ptr_q == PtrW'(LINE_W - 1)) ? '0 : ptr_q + 1'b1;
      fill_d      = (fill_q == FillW'(FillMax)) ? fill_q : fill_q + 1'b1;
      // Each row shifts left; column 2 takes the newest sample of that row.
      win_d[0]    = win_q[1];
      win_d[1]    = win_q[2];
      win_d[2]    = line2_out;
      win_d[3]    = win_q[4];
      win_d[4]    = win_q[5];
      win_d[5]    = line1_out;
      win_d[6]    = win_q[7];
      win_d[7]    = win_q[8];
      win_d[8]    = din;
      win_valid_d = (fill_q == FillW'(FillMax));
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      fill_q      <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      fill_q      <= fill_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign bus.win_data  = win_q;
  assign bus.win_valid = win_valid_q;
endmodule

// File: tb/tb_win3x3_gen.sv
// Self-checking bench for win3x3_gen (LINE_W=4, DW=8): vector table, corner sequences, random vs model.
module tb_win3x3_gen;
  localparam int unsigned DW    = 8;
  localparam int unsigned LW    = 4;
  localparam int unsigned FillN = 2 * LW + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  win3x3_gen_if #(.DW(DW)) bus ();

  win3x3_gen #(.DW(DW), .LINE_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .state (state),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic        iv;
    logic        wr;
    logic        e_rdy;
    logic        e_valid;
    logic        chk;
    logic [71:0] e_win;
  } vec_t;

  vec_t tbl[18];

  // Reference model: every accepted sample in arrival order.
  logic [7:0]  hist[$];
  logic        m_valid;
  logic [71:0] m_win;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Window whose oldest tap is sample value 'base' in a stream valued index+1.
  function automatic logic [71:0] pack9(input int unsigned base);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'(base + (k / 3) * LW + (k % 3));
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_valid = 1'b0;
    m_win   = '0;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    state        = 4'b0000;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.win_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive, check outputs against the model, step, update the model.
  task automatic cycle(input logic [3:0] st, input logic iv, input logic [7:0] d, input logic wr);
    logic       stall, adv, exp_rdy;
    logic [7:0] din;
    int         n;
    state         = st;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.win_ready = wr;
    #2;
    stall   = m_valid && !wr;
    exp_rdy = !stall && (st[0] || st[1]);
    check("in_ready", 72'(bus.in_ready), 72'(exp_rdy));
    check("win_valid", 72'(bus.win_valid), 72'(m_valid));
    if (m_valid) check("win_data", bus.win_data, m_win);
    adv = exp_rdy && iv;
    din = d;
`ifdef WIN3X3_FLUSH_EN
    if (!stall && st[2]) begin
      adv = 1'b1;
      din = 8'h00;
    end
`endif
    @(posedge clk);
    #1;
    if (adv) begin
      hist.push_back(din);
      n = hist.size() - 1;
      if (hist.size() >= FillN) begin
        m_valid = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            m_win[8*(r*3+c) +: 8] = hist[n - (2 - r) * LW - (2 - c)];
      end else begin
        m_valid = 1'b0;
      end
    end else if (wr) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    int          acc;
    int          wins;
    logic [3:0]  st;
    int unsigned pick;

    // Table: fill, 5-cycle backpressure, release.
    for (int i = 0; i < 11; i++) tbl[i] = '{4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 72'h0};
    for (int i = 11; i < 16; i++) tbl[i] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pack9(1)};
    tbl[16] = '{4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, pack9(1)};
    tbl[17] = '{4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, pack9(2)};

    rst_n         = 1'b0;
    state         = 4'b0000;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.win_ready = 1'b0;
    #2;
    check("reset win_valid", 72'(bus.win_valid), 72'h0);
    check("reset win_data", bus.win_data, 72'h0);
    check("reset in_ready", 72'(bus.in_ready), 72'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    acc = 0;
    foreach (tbl[i]) begin
      state         = tbl[i].st;
      bus.in_valid  = tbl[i].iv;
      bus.in_data   = 8'(acc + 1);
      bus.win_ready = tbl[i].wr;
      #2;
      check($sformatf("vec%0d in_ready", i), 72'(bus.in_ready), 72'(tbl[i].e_rdy));
      check($sformatf("vec%0d win_valid", i), 72'(bus.win_valid), 72'(tbl[i].e_valid));
      if (tbl[i].chk) check($sformatf("vec%0d win_data", i), bus.win_data, tbl[i].e_win);
      if (tbl[i].iv && tbl[i].e_rdy) acc++;
      @(posedge clk);
      #1;
    end

    // Bubbles: in_valid toggling.
    do_reset();
    for (int i = 0; i < 40; i++) cycle(4'b0001, 1'(i % 2 == 0), 8'(hist.size() + 1), 1'b1);

    // Asynchronous reset while a window is valid.
    do_reset();
    for (int i = 0; i < 12; i++) cycle(4'b0001, 1'b1, 8'(hist.size() + 1), 1'b1);
    check("pre-reset win_valid", 72'(bus.win_valid), 72'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset win_valid", 72'(bus.win_valid), 72'h0);
    check("async reset win_data", bus.win_data, 72'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Reset after 7 samples, then a full refill is needed.
    for (int i = 0; i < 7; i++) cycle(4'b0001, 1'b1, 8'(hist.size() + 1), 1'b1);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(4'b0001, 1'b1, 8'(hist.size() + 1), 1'b1);
    check("refill 10 win_valid", 72'(bus.win_valid), 72'h0);
    cycle(4'b0001, 1'b1, 8'(hist.size() + 1), 1'b1);
    check("refill 11 win_valid", 72'(bus.win_valid), 72'h1);
    check("refill 11 win_data", bus.win_data, pack9(1));

    // Flush phase after 16 samples.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(4'b0001, 1'b1, 8'(hist.size() + 1), 1'b1);
    wins = 0;
    for (int i = 0; i < 11; i++) begin
      cycle(4'b0100, 1'b1, 8'hAA, 1'b1);
      if (bus.win_valid) wins++;
      if (i == 0) begin
`ifdef WIN3X3_FLUSH_EN
        check("flush first tap8", 72'(bus.win_data[71:64]), 72'h0);
`else
        check("no-flush first valid", 72'(bus.win_valid), 72'h0);
`endif
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1000, 1'b1, 8'hAA, 1'b1);
      if (bus.win_valid) wins++;
    end
`ifdef WIN3X3_FLUSH_EN
    check("flush window count", 72'(wins), 72'd11);
`else
    check("no-flush window count", 72'(wins), 72'd0);
`endif

    // Random traffic, including state changes during stalls.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 5)       st = 4'b0001;
      else if (pick < 7)  st = 4'b0010;
      else if (pick == 7) st = 4'b0100;
      else if (pick == 8) st = 4'b1000;
      else                st = 4'b0000;
      cycle(st, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/win3x3_gen.md
WIN3X3_GEN -- requirements
Module: win3x3_gen

Interface
REQ-001 SHALL have parameter DW, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter LINE_W, default 1026, meaning samples per padded line.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port state  input  4  one-hot phase from the pixel counter: 0001 buffering, 0010 buffer done, 0100 picture input done, 1000 process done.
REQ-006 SHALL have port in_data  input  DW  stream pixel.
REQ-007 SHALL have port in_valid  input  1  upstream valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data.
REQ-009 SHALL have port win_data  output  9*DW  3x3 window, tap k=r*3+c at [DW*k +: DW].
REQ-010 SHALL have port win_valid  output  1  window valid.
REQ-011 SHALL have port win_ready  input  1  downstream accepts window.

Function
REQ-012 SHALL define stall = win_valid && !win_ready.
REQ-013 SHALL drive in_ready = !stall && (state[0] || state[1]), combinationally.
REQ-014 SHALL perform one advance per cycle when (state[0]||state[1]) && in_valid && in_ready, shifting in in_data.
REQ-015 SHALL perform no advance in state 1000, in state 0000, or while stall is high.
REQ-016 SHALL, after advance number N (0-based), present tap (r,c) = sample N-(2-r)*LINE_W-(2-c); tap 8 is the newest sample and tap 0 the oldest.
REQ-017 SHALL hold a saturating fill count of advances; win_valid SHALL first assert on the cycle after advance 2*LINE_W+2 and stay meaningful for every later advance.
REQ-018 SHALL register win_data and win_valid, giving one-cycle latency from advance to window.
REQ-019 SHALL deassert win_valid on a cycle with win_ready high and no advance; it SHALL assert win_valid on every cycle following an advance once filled.
REQ-020 SHALL hold win_data and win_valid stable while stall is high, with no window dropped or duplicated.
REQ-021 SHALL implement the line delays as two LINE_W-deep delay stages whose pointer wraps from LINE_W-1 to 0 with no gap or skip.
REQ-022 SHALL give a state change arriving during a stall no effect until the stall clears.

Reset
REQ-023 SHALL, on rst_n low, clear win_valid, win_data, the fill count, the window registers and the delay pointers immediately, regardless of clk.
REQ-024 SHALL NOT require reset of delay-line storage; unfilled contents SHALL never reach win_data while win_valid is high.
REQ-025 SHALL, when reset is applied mid-frame, discard the partial frame; refill SHALL restart at advance 0.

Configuration
REQ-026 SHALL honour macro WIN3X3_FLUSH_EN.
REQ-027 SHALL, with WIN3X3_FLUSH_EN defined, perform one advance with in_data replaced by zero on each cycle in state 0100 with !stall, draining the last 2*LINE_W+3 windows.
REQ-028 SHALL, without WIN3X3_FLUSH_EN, perform no advance in state 0100, and in_ready SHALL be 0 there.

Verification (LINE_W=4, DW=8, sample value = index+1)
REQ-029 Fill: state=0001, in_valid=1 constantly, win_ready=1 -> win_valid rises the cycle after the 11th accepted sample; taps k0..k8 = 1,2,3,5,6,7,9,10,11.
REQ-030 Backpressure: win_ready=0 for 5 cycles after fill -> in_ready=0, win_data frozen at 1,2,3,5,6,7,9,10,11; on release the next window = 2,3,4,6,7,8,10,11,12.
REQ-031 Bubbles: in_valid toggling 1/0 -> win_valid pulses only after accepted samples; window sequence identical to REQ-029/REQ-030 order.
REQ-032 Flush (macro on): 16 samples, then state=0100 with win_ready=1 -> 11 more windows with zeros entering tap 8; in_ready=0 throughout.
REQ-033 Flush (macro off): same stimulus -> no windows after state=0100; in_ready=0.
REQ-034 Reset mid-frame: rst_n low after 7 samples -> win_valid=0 at once; after release, 11 fresh samples are needed before win_valid asserts.
